// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bus-level constants and byte geometry.
package i2c_pkg;

  localparam int   BYTE_W = 8;
  localparam int   RW_BIT = 0;
  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Oversamples SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;

  // Chains reset to the idle-bus level so release of reset never fakes an edge on SDA.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target exposing one 16-bit read word and one 16-bit write word at a single address.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] rd_data,
  output logic [15:0] wr_data,
  output logic        wr_valid,
  output logic        busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_det),
    .stop     (stop_det),
    .sda_s    (sda_s)
  );

  i2c_state_e        state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_valid_q, wr_valid_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [15:0]       shadow_q, shadow_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] shift_in, rd_byte;

  assign shift_in = {shift_q[BYTE_W-2:0], sda_s};
  assign rd_byte  = ptr_q ? shadow_q[7:0] : shadow_q[15:8];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      ptr_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
    shadow_q <= shadow_d;
  end

  // In the ACK states sda_oe_q doubles as the phase flag: first SCL fall drives, second ends the slot.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_data_d  = wr_data_q;
    shadow_d   = shadow_q;
    shift_d    = shift_q;
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      ptr_d     = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (shift_in[7:1] == SLAVE_ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
                if (shift_in[RW_BIT]) shadow_d = rd_data;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (shift_q[RW_BIT]) begin
              state_d   = ST_RD_BYTE;
              sda_oe_d  = ~rd_byte[7];
              bit_cnt_d = 4'd0;
            end else begin
              state_d   = ST_WR_BYTE;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end
          end
        end
        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              state_d   = ST_WR_ACK;
              ptr_d     = ~ptr_q;
              if (ptr_q) begin
                wr_data_d[7:0] = shift_in;
                wr_valid_d     = 1'b1;
              end else begin
                wr_data_d[15:8] = shift_in;
              end
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_BYTE;
            end
          end
        end
        ST_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RD_ACK;
            end else begin
              sda_oe_d = ~rd_byte[3'd7 - bit_cnt_q[2:0]];
            end
          end
        end
        ST_RD_ACK: begin
          // Counter parks at 8 until the master ACKs; 0 marks "next byte armed".
          if (scl_rise) begin
            if (sda_s == ACK) begin
              ptr_d     = ~ptr_q;
              bit_cnt_d = 4'd0;
            end else begin
              state_d  = ST_IGNORE;
              sda_oe_d = 1'b0;
            end
          end else if (scl_fall && bit_cnt_q == 4'd0) begin
            sda_oe_d = ~rd_byte[7];
            state_d  = ST_RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench: bus-level master driver, transaction-level expectation model and per-cycle output compare.
module tb_i2c_slave_responder;

  localparam logic [6:0] ADDR = 7'h50;
  localparam int         Q    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_w;
  logic        sda_oe;
  logic [15:0] rd_data = 16'h0000;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        busy;

  assign sda_w = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_responder #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda_in   (sda_w),
    .sda_oe   (sda_oe),
    .rd_data  (rd_data),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .busy     (busy)
  );

  // Expected outputs as implied by the transactions the master has performed so far.
  logic        exp_oe = 1'b0;
  logic [15:0] m_wr = 16'h0000;
  logic [15:0] m_shadow = 16'h0000;
  logic        m_busy = 1'b0;
  logic        m_ptr = 1'b0;
  int          m_mode = 0;      // 0 not addressed, 1 write, 2 read
  int          m_vcnt = 0;
  int          dut_vcnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  int          quiet = 0;
  logic        scl_l = 1'b1, sda_l = 1'b1, rst_l = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (scl !== scl_l || sda_m !== sda_l || reset !== rst_l) quiet = 0;
    else if (quiet < 1000) quiet++;
    scl_l = scl;
    sda_l = sda_m;
    rst_l = reset;
    if (wr_valid === 1'b1) dut_vcnt++;
    if (chk_en && reset && quiet >= 5) begin
      check("sda_oe", {31'd0, sda_oe}, {31'd0, exp_oe});
      check("wr_data", {16'd0, wr_data}, {16'd0, m_wr});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("wr_valid_quiet", {31'd0, wr_valid}, 32'd0);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rise_bit(input logic b);
    clks(Q); sda_m = b;
    clks(Q); scl = 1'b1;
  endtask

  task automatic fall_bit(output logic s);
    clks(Q); s = sda_w;
    clks(Q); scl = 1'b0;
  endtask

  task automatic start_cond();
    if (!scl) begin
      clks(Q); sda_m = 1'b1;
      clks(Q); scl = 1'b1;
    end
    clks(Q); sda_m = 1'b0;
    exp_oe = 1'b0; m_ptr = 1'b0; m_mode = 0;
    clks(Q); scl = 1'b0;
  endtask

  task automatic stop_cond();
    clks(Q); sda_m = 1'b0;
    clks(Q); scl = 1'b1;
    clks(Q); sda_m = 1'b1;
    exp_oe = 1'b0; m_busy = 1'b0; m_mode = 0;
    clks(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_addr, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      rise_bit(b[i]);
      if (i == 0) begin
        if (is_addr) begin
          if (b[7:1] == ADDR) begin
            m_busy = 1'b1; m_ptr = 1'b0;
            m_mode = b[0] ? 2 : 1;
            if (b[0]) m_shadow = rd_data;
          end else begin
            m_mode = 0;
          end
        end else if (m_mode == 1) begin
          if (m_ptr) begin m_wr[7:0] = b; m_vcnt++; end
          else m_wr[15:8] = b;
          m_ptr = ~m_ptr;
        end
      end
      fall_bit(s);
      if (i == 0) exp_oe = (m_mode != 0);
    end
    rise_bit(1'b1);
    fall_bit(s);
    acked = ~s;
    exp_oe = (m_mode == 2) ? ~m_shadow[15] : 1'b0;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] got);
    logic s;
    logic [7:0] cur, nxt;
    cur = m_ptr ? m_shadow[7:0] : m_shadow[15:8];
    for (int i = 7; i >= 0; i--) begin
      rise_bit(1'b1);
      fall_bit(s);
      got[i] = s;
      if (i > 0) exp_oe = ~cur[i-1];
      else exp_oe = 1'b0;
    end
    rise_bit(~mack);
    if (mack) m_ptr = ~m_ptr;
    else m_mode = 0;
    fall_bit(s);
    nxt = m_ptr ? m_shadow[7:0] : m_shadow[15:8];
    exp_oe = mack ? ~nxt[7] : 1'b0;
  endtask

  initial begin
    logic       ack;
    logic [7:0] g;
    int         v0;

    // Reset state
    clks(10);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_wr_data", {16'd0, wr_data}, 32'h0000);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    clks(10);

    // Wrong address: never ACKed, nothing written
    start_cond();
    send_byte({7'h51, 1'b0}, 1'b1, ack);
    check("wrong_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h5A, 1'b0, ack);
    check("wrong_addr_data_ack", {31'd0, ack}, 32'd0);
    stop_cond();
    check("wrong_addr_wr_data", {16'd0, wr_data}, 32'h0000);

    // Two-byte write
    v0 = dut_vcnt;
    start_cond();
    send_byte({ADDR, 1'b0}, 1'b1, ack);
    check("wr_addr_ack", {31'd0, ack}, 32'd1);
    check("wr_busy", {31'd0, busy}, 32'd1);
    send_byte(8'hAB, 1'b0, ack);
    check("wr_b0_ack", {31'd0, ack}, 32'd1);
    send_byte(8'hCD, 1'b0, ack);
    check("wr_b1_ack", {31'd0, ack}, 32'd1);
    stop_cond();
    check("wr_data_abcd", {16'd0, wr_data}, 32'hABCD);
    check("wr_valid_once", dut_vcnt - v0, 32'd1);
    check("wr_busy_after_stop", {31'd0, busy}, 32'd0);

    // Two-byte read; rd_data changes after the address must not matter
    rd_data = 16'h1234;
    start_cond();
    send_byte({ADDR, 1'b1}, 1'b1, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd1);
    rd_data = 16'hFFFF;
    recv_byte(1'b1, g);
    check("rd_byte0", {24'd0, g}, 32'h12);
    recv_byte(1'b0, g);
    check("rd_byte1", {24'd0, g}, 32'h34);
    clks(6);
    check("rd_released_after_nack", {31'd0, sda_oe}, 32'd0);
    stop_cond();

    // Three-byte write wraps the pointer to the high byte
    v0 = dut_vcnt;
    start_cond();
    send_byte({ADDR, 1'b0}, 1'b1, ack);
    send_byte(8'h11, 1'b0, ack);
    send_byte(8'h22, 1'b0, ack);
    send_byte(8'h33, 1'b0, ack);
    check("wr3_ack", {31'd0, ack}, 32'd1);
    stop_cond();
    check("wr3_data", {16'd0, wr_data}, 32'h3322);
    check("wr3_valid_once", dut_vcnt - v0, 32'd1);

    // Write one byte, repeated START, then read
    v0 = dut_vcnt;
    rd_data = 16'h9876;
    start_cond();
    send_byte({ADDR, 1'b0}, 1'b1, ack);
    send_byte(8'hAB, 1'b0, ack);
    start_cond();
    send_byte({ADDR, 1'b1}, 1'b1, ack);
    check("rs_addr_ack", {31'd0, ack}, 32'd1);
    recv_byte(1'b0, g);
    check("rs_rd_byte", {24'd0, g}, 32'h98);
    stop_cond();
    check("rs_wr_data", {16'd0, wr_data}, 32'hAB22);
    check("rs_no_valid", dut_vcnt - v0, 32'd0);

    // Reset while driving a read bit low
    rd_data = 16'h1234;
    start_cond();
    send_byte({ADDR, 1'b1}, 1'b1, ack);
    clks(6);
    check("mid_rd_driving", {31'd0, sda_oe}, 32'd1);
    reset = 1'b0;
    m_wr = 16'h0000; m_busy = 1'b0; exp_oe = 1'b0; m_mode = 0; m_ptr = 1'b0;
    clks(1);
    check("mid_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("mid_rst_wr_data", {16'd0, wr_data}, 32'h0000);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    clks(4);
    reset = 1'b1;
    stop_cond();
    start_cond();
    send_byte({ADDR, 1'b0}, 1'b1, ack);
    check("post_rst_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h5C, 1'b0, ack);
    stop_cond();
    check("post_rst_wr_data", {16'd0, wr_data}, 32'h5C00);

    // Randomized transactions against the model
    for (int t = 0; t < 20; t++) begin
      int kind, nb;
      logic [6:0]  a;
      logic [15:0] rdv;
      logic [7:0]  b;
      kind = $urandom_range(0, 2);
      start_cond();
      if (kind == 0) begin
        nb = $urandom_range(1, 3);
        send_byte({ADDR, 1'b0}, 1'b1, ack);
        check("rnd_wr_addr_ack", {31'd0, ack}, 32'd1);
        for (int k = 0; k < nb; k++) begin
          b = 8'($urandom);
          send_byte(b, 1'b0, ack);
          check("rnd_wr_ack", {31'd0, ack}, 32'd1);
        end
      end else if (kind == 1) begin
        nb = $urandom_range(1, 3);
        rdv = 16'($urandom);
        rd_data = rdv;
        send_byte({ADDR, 1'b1}, 1'b1, ack);
        check("rnd_rd_addr_ack", {31'd0, ack}, 32'd1);
        rd_data = 16'($urandom);
        for (int k = 0; k < nb; k++) begin
          recv_byte(k != nb - 1, g);
          check("rnd_rd_byte", {24'd0, g}, {24'd0, (k % 2 == 0) ? rdv[15:8] : rdv[7:0]});
        end
      end else begin
        a = 7'($urandom);
        if (a == ADDR) a = ADDR + 7'd1;
        send_byte({a, 1'($urandom)}, 1'b1, ack);
        check("rnd_bad_addr_ack", {31'd0, ack}, 32'd0);
        send_byte(8'($urandom), 1'b0, ack);
        check("rnd_bad_data_ack", {31'd0, ack}, 32'd0);
      end
      stop_cond();
    end
    check("valid_count_total", dut_vcnt, m_vcnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C target (responder) answering the team's I2C master over an open-drain SCL/SDA pair; used as the far end of server_client in system-level benches and on-board loopback.
- Exposes one 16-bit readable word (rd_data) and one 16-bit writable word (wr_data) at a single 7-bit address.
- Fully synchronous to the system clock; SCL/SDA are oversampled, never used as clocks. Never stretches SCL.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address answered.
- SYNC_STAGES, 2, synchronizer depth on scl/sda_in (≥2).

Ports:
- clk  input  1  system clock; must be ≥ 8× SCL frequency.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- scl  input  1  bus clock as seen on the wire.
- sda_in  input  1  bus data as seen on the wire.
- sda_oe  output  1  1 = pull SDA low, 0 = release (open-drain; pad ties output to 0).
- rd_data  input  16  word returned on reads, MSB byte first.
- wr_data  output  16  last bytes written by master.
- wr_valid  output  1  one-cycle pulse when the low byte of wr_data is updated.
- busy  output  1  high from addressed START until STOP.

Behaviour:
- Reset (reset=0): state IDLE, sda_oe=0, wr_data=16'h0000, wr_valid=0, busy=0, bit counter and byte pointer 0. Reset mid-transfer releases SDA on the next clk edge.
- Inputs pass a SYNC_STAGES flop chain; rise/fall detected on the last two stages. All bus responses lag the wire by SYNC_STAGES+1 clk.
- START = synced SDA fall while SCL high; STOP = SDA rise while SCL high. Both override any state: START → ADDR (bit count 0, sda_oe=0, repeated START allowed); STOP → IDLE, sda_oe=0, busy=0.
- Data is sampled on SCL rise, driven/changed only on SCL fall (one clk after fall detected).
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- ADDR: shift 8 bits MSB first. After 8th rise: addr[7:1]==SLAVE_ADDR → ADDR_ACK, busy=1; else IGNORE (sda_oe stays 0 until START/STOP).
- ADDR_ACK: on next SCL fall sda_oe=1; on following fall sda_oe released (write) or first data bit driven (read). R/W=1 snapshots rd_data into a 16-bit shadow at the 8th address rise; later rd_data changes do not affect the transfer.
- WR_BYTE/WR_ACK: 8 bits in; always ACKed. Pointer 0 → wr_data[15:8]; pointer 1 → wr_data[7:0] plus wr_valid pulse one clk after 8th rise. Pointer toggles per byte (3rd byte wraps to high byte, no pulse).
- RD_BYTE: sda_oe = ~bit of current shadow byte, MSB first. After 8th bit SDA released for the ACK slot.
- RD_ACK: master ACK (SDA=0 at 9th rise) → next byte, pointer toggles (wraps to high byte after low byte); NACK → IGNORE with SDA released.
- A STOP/START during any data bit aborts the byte; partial bytes never update wr_data.
- Simultaneous START detect and reset: reset wins.

Decomposition:
- Shared package i2c_pkg: state encoding, ACK/NACK constants, R/W bit index, byte width 8.
- One sub-module i2c_bus_sync: synchronizer + edge/START/STOP detector (outputs scl_rise, scl_fall, start, stop, sda_s); reusable by the master.

Test Plan:
- Write 0x50+W, bytes 0xAB,0xCD, STOP → three ACKs, wr_data=16'hABCD, single wr_valid pulse, busy low after STOP.
- rd_data=16'h1234, read 0x50+R, master ACK then NACK → bytes 0x12,0x34 on SDA, sda_oe=0 after NACK.
- Address 0x51+W → no ACK (sda_oe never 1), wr_data unchanged 16'h0000.
- Write 0xAB, repeated START, read → read returns rd_data high byte; wr_data[15:8]=0xAB, no wr_valid.
- reset=0 asserted while driving a read bit low → sda_oe=0 next clk, wr_data=0, state IDLE.
- Three-byte write 0x11,0x22,0x33 → wr_data=16'h3322 after STOP, one wr_valid pulse.
